// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - fetch/decode boundary signals between the IF/ID stage and its surroundings
interface if_id_stage_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      imem_data;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic [31:0]      pc_out;
    logic [31:0]      ifid_instr;
    logic [31:0]      ifid_npc;
    logic             ifid_valid;
    logic             id_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  imem_data, branch_taken, branch_target, idex_memread, idex_rt,
        output pc_out, ifid_instr, ifid_npc, ifid_valid, id_bubble, stall_cnt, flush_cnt
    );

    modport slave (
        output imem_data, branch_taken, branch_target, idex_memread, idex_rt,
        input  pc_out, ifid_instr, ifid_npc, ifid_valid, id_bubble, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - PC, IF/ID register, load-use stall and taken-branch flush
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic          clk,
    input  logic          reset,
    if_id_stage_if.master bus
);
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic [31:0]      npc_q;
    logic             valid_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        load_use;
    logic [31:0] pc_plus4;

    always_comb begin
        rs       = instr_q[25:21];
        rt       = instr_q[20:16];
        // rt is compared for every opcode: conservative, never misses a real hazard
        load_use = valid_q && bus.idex_memread && (bus.idex_rt != 5'd0) &&
                   ((bus.idex_rt == rs) || (bus.idex_rt == rt));
        pc_plus4 = pc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            npc_q   <= 32'd0;
            valid_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else if (bus.branch_taken) begin
            // flush beats stall; the NOP left behind is invalid so it cannot stall later
            pc_q    <= bus.branch_target & 32'hFFFF_FFFC;
            instr_q <= 32'd0;
            npc_q   <= 32'd0;
            valid_q <= 1'b0;
            if (flush_q != {CNT_W{1'b1}}) begin
                flush_q <= flush_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (load_use) begin
            if (stall_q != {CNT_W{1'b1}}) begin
                stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            pc_q    <= pc_plus4;
            instr_q <= bus.imem_data;
            npc_q   <= pc_plus4;
            valid_q <= 1'b1;
        end
    end

    assign bus.pc_out     = pc_q;
    assign bus.ifid_instr = instr_q;
    assign bus.ifid_npc   = npc_q;
    assign bus.ifid_valid = valid_q;
    assign bus.id_bubble  = reset || bus.branch_taken || load_use;
    assign bus.stall_cnt  = stall_q;
    assign bus.flush_cnt  = flush_q;
endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - randomized and directed bench for if_id_stage against a behavioural model
module tb_if_id_stage;
    localparam int          CNT_W    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_id_stage_if #(.CNT_W(CNT_W)) bus ();

    if_id_stage #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:255];
    always_comb bus.imem_data = mem[bus.pc_out[9:2]];

    logic [31:0] m_pc, m_instr, m_npc;
    logic        m_valid;
    int          m_scnt, m_fcnt;
    int          total = 0;
    int          bad   = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic b, input logic [31:0] t,
                        input logic mr, input logic [4:0] rt);
        logic lu;
        @(negedge clk);
        reset             = r;
        bus.branch_taken  = b;
        bus.branch_target = t;
        bus.idex_memread  = mr;
        bus.idex_rt       = rt;
        #1;
        lu = m_valid && mr && (rt != 5'd0) && (rt == m_instr[25:21] || rt == m_instr[20:16]);
        check32("id_bubble", {31'd0, bus.id_bubble}, {31'd0, (r | b | lu)});
        @(posedge clk);
        if (r) begin
            m_pc = RESET_PC; m_instr = 0; m_npc = 0; m_valid = 0; m_scnt = 0; m_fcnt = 0;
        end else if (b) begin
            m_pc = {t[31:2], 2'b00}; m_instr = 0; m_npc = 0; m_valid = 0;
            m_fcnt = (m_fcnt < CNT_MAX) ? m_fcnt + 1 : CNT_MAX;
        end else if (lu) begin
            m_scnt = (m_scnt < CNT_MAX) ? m_scnt + 1 : CNT_MAX;
        end else begin
            m_instr = mem[m_pc[9:2]];
            m_pc    = m_pc + 32'd4;
            m_npc   = m_pc;
            m_valid = 1'b1;
        end
        #1;
        check32("pc_out",     bus.pc_out,     m_pc);
        check32("ifid_instr", bus.ifid_instr, m_instr);
        check32("ifid_npc",   bus.ifid_npc,   m_npc);
        check32("ifid_valid", {31'd0, bus.ifid_valid}, {31'd0, m_valid});
        check32("stall_cnt",  32'(bus.stall_cnt), 32'(m_scnt));
        check32("flush_cnt",  32'(bus.flush_cnt), 32'(m_fcnt));
    endtask

    initial begin
        int sel;
        logic [4:0] rtv;
        reset = 1'b1;
        bus.branch_taken = 0; bus.branch_target = 0; bus.idex_memread = 0; bus.idex_rt = 0;
        m_pc = 0; m_instr = 0; m_npc = 0; m_valid = 0; m_scnt = 0; m_fcnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[64] = 32'h2002_0005;
        mem[65] = 32'h0043_2020;

        step(1, 0, 0, 0, 0);
        check32("reset_pc", bus.pc_out, 32'h100);
        step(0, 0, 0, 0, 0);
        check32("release_instr", bus.ifid_instr, 32'h2002_0005);
        check32("release_npc",   bus.ifid_npc,   32'h104);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 5'd2);
        check32("stall_hold_pc", bus.pc_out, 32'h108);
        check32("stall_cnt_one", 32'(bus.stall_cnt), 32'd1);
        step(0, 0, 0, 1, 5'd7);
        step(0, 0, 32'h104, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 5'd0);
        step(0, 1, 32'h203, 1, 5'd3);
        step(0, 0, 0, 0, 0);
        step(0, 1, 32'h104, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 32'h0000_0203, 1, 5'd2);
        check32("branch_pc", bus.pc_out, 32'h200);
        step(0, 0, 0, 1, 5'd0);
        step(0, 1, 32'hFFFF_FFFF, 0, 0);
        step(0, 0, 0, 0, 0);
        check32("wrap_pc",  bus.pc_out,   32'h0);
        check32("wrap_npc", bus.ifid_npc, 32'h0);
        for (int i = 0; i < 5; i++) step(0, 1, $urandom, 0, 0);
        check32("flush_sat", 32'(bus.flush_cnt), 32'd3);
        step(1, 1, 32'h40, 1, 5'd2);
        check32("reset_clr", 32'(bus.flush_cnt), 32'd0);

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       rtv = m_instr[25:21];
                1:       rtv = m_instr[20:16];
                2:       rtv = 5'd0;
                default: rtv = 5'($urandom);
            endcase
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), $urandom,
                 ($urandom_range(0, 2) != 0), rtv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch-side stage of the 5-stage MIPS pipeline. Owns the program counter and the IF/ID pipeline register, detects load-use hazards against the ID/EX register and handles taken-branch redirects. Sits directly upstream of the ID/EX pipeline register and feeds it. Its decoded instruction, next-PC and bubble request become the ID/EX register's inputs through the decode logic.

## Interface
- RESET_PC, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 00.
- CNT_W, default 16: width of the saturating stall and flush counters.

- CLK  input  1  rising-edge clock for every register in the block.
- RESET  input  1  synchronous, active-high reset; sampled on the rising edge of CLK.
- IMEM_DATA  input  32  instruction word read combinationally from instruction memory at PC_OUT.
- BRANCH_TAKEN  input  1  a branch or jump has resolved as taken; redirect fetch.
- BRANCH_TARGET  input  32  redirect address; bits [1:0] are ignored and treated as 00.
- IDEX_MEMREAD  input  1  the instruction currently in ID/EX is a load.
- IDEX_RT  input  5  destination register of the instruction currently in ID/EX.
- PC_OUT  output  32  current fetch address driven to instruction memory (registered).
- IFID_INSTR  output  32  instruction held in IF/ID (registered).
- IFID_NPC  output  32  PC+4 of the held instruction (registered).
- IFID_VALID  output  1  the IF/ID contents are a real instruction (registered).
- ID_BUBBLE  output  1  combinational; when high, ID/EX loads all-zero control signals this edge.
- STALL_CNT  output  CNT_W  number of load-use stall cycles, saturating.
- FLUSH_CNT  output  CNT_W  number of taken-branch flush cycles, saturating.

## Operation
- Decode fields: rs = IFID_INSTR[25:21], rt = IFID_INSTR[20:16].
- load_use = IFID_VALID & IDEX_MEMREAD & (IDEX_RT != 0) & ((IDEX_RT == rs) | (IDEX_RT == rt)).
  - The rt compare is conservative and applies for every opcode.
- ID_BUBBLE = RESET | BRANCH_TAKEN | load_use.
- Per-edge action, in priority order:
  - RESET:
    - PC_OUT <= RESET_PC.
    - IFID_INSTR <= 0; IFID_NPC <= 0; IFID_VALID <= 0.
    - STALL_CNT <= 0; FLUSH_CNT <= 0.
  - BRANCH_TAKEN (flush):
    - PC_OUT <= {BRANCH_TARGET[31:2], 2'b00}.
    - IFID_INSTR <= 0 (NOP); IFID_NPC <= 0; IFID_VALID <= 0.
    - FLUSH_CNT increments.
    - Overrides load_use; STALL_CNT does not increment.
  - load_use (stall):
    - PC_OUT, IFID_INSTR, IFID_NPC and IFID_VALID hold their values.
    - STALL_CNT increments.
  - Otherwise (advance):
    - PC_OUT <= PC_OUT + 4.
    - IFID_INSTR <= IMEM_DATA; IFID_NPC <= PC_OUT + 4; IFID_VALID <= 1.
- Arithmetic: PC increments modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000. Both counters saturate at 2^CNT_W - 1.
- Stall length: the bubble makes IDEX_MEMREAD low on the following cycle, so a lone load-use stall lasts exactly 1 cycle. Back-to-back stalls occur only if the upstream inputs keep IDEX_MEMREAD asserted.
- An invalid IF/ID entry (IFID_VALID = 0) never causes a stall. This includes the NOP left behind by a flush.
- IDEX_RT = 0 never causes a stall.

## Timing
- Every register updates on the rising edge of CLK. Reset is synchronous and takes effect on the first edge where RESET is high.
- After RESET is released, the first edge loads the instruction at RESET_PC into IF/ID. IFID_VALID goes high 1 cycle after reset release.
- ID_BUBBLE is combinational and is valid in the same cycle as its causing inputs. It must settle before the next CLK edge.
- Branch penalty inside this block: 1 flushed IF/ID slot. IMEM_DATA for BRANCH_TARGET is captured on the edge after the redirect.
- RESET during a stall or flush: reset wins. No counter increments on that edge.
- BRANCH_TAKEN and load_use in the same cycle: flush wins. FLUSH_CNT increments and STALL_CNT does not.

## Test plan
- Reset release with RESET_PC = 0x100 and IMEM returning 0x2002_0005 at 0x100 -> after 1 edge:
  - PC_OUT = 0x104, IFID_INSTR = 0x2002_0005, IFID_NPC = 0x104, IFID_VALID = 1.
- Load-use: IFID_INSTR = 0x0043_2020 (add $4,$2,$3), IDEX_MEMREAD = 1, IDEX_RT = 2 ->
  - ID_BUBBLE = 1 in the same cycle.
  - PC and IF/ID hold for exactly 1 edge; STALL_CNT = 1.
  - On the next cycle, with IDEX_MEMREAD = 0, the pipeline advances.
- Load with IDEX_RT = 0 or IDEX_RT = 7 (no match) against the same instruction -> no stall; ID_BUBBLE = 0.
- BRANCH_TAKEN = 1, BRANCH_TARGET = 0x0000_0203, with load_use also true ->
  - PC_OUT = 0x200, IFID_INSTR = 0, IFID_VALID = 0.
  - FLUSH_CNT = 1 and STALL_CNT unchanged.
- PC wrap: force PC_OUT to 0xFFFF_FFFC through a branch, then advance -> PC_OUT = 0x0000_0000 and IFID_NPC = 0x0000_0000.
- Counter saturation with CNT_W = 2 and 5 consecutive flushes -> FLUSH_CNT stays at 3. A reset mid-sequence clears both counters to 0.
